// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: RGB565 valid/ready stream to the 80x60 RGB444 frame-buffer write port.
// Define FB_WRITER_DOUBLE_BUF_EN to add a bank bit to wr_addr and flip rd_bank per completed frame.
//
// state | meaning
// IDLE  | waiting for an in_sof beat; in_sof is dropped while freeze is high
// WRITE | frame in progress, one registered write per accepted beat
// DONE  | one-cycle bubble after the last pixel; frame_done pulses
module fb_pixel_writer #(
    parameter int C_COLS      = 80,
    parameter int C_ROWS      = 60,
    parameter int C_ADDR_BITS = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   freeze,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_sof,
    input  logic [15:0]            in_data,
    output logic                   wr_en,
`ifdef FB_WRITER_DOUBLE_BUF_EN
    output logic [C_ADDR_BITS:0]   wr_addr,
`else
    output logic [C_ADDR_BITS-1:0] wr_addr,
`endif
    output logic [11:0]            wr_data,
    output logic                   rd_bank,
    output logic                   frame_done,
    output logic                   err_short,
    output logic [7:0]             frame_cnt
);
    localparam int COL_W = (C_COLS > 1) ? $clog2(C_COLS) : 1;
    localparam int ROW_W = (C_ROWS > 1) ? $clog2(C_ROWS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(C_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(C_ROWS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, DONE} state_t;

    state_t                 state;
    logic [COL_W-1:0]       col;
    logic [ROW_W-1:0]       row;
    logic [C_ADDR_BITS-1:0] addr;

    logic                   accept;
    logic                   start;
    logic                   do_write;
    logic                   last;
    logic [COL_W-1:0]       pos_col;
    logic [ROW_W-1:0]       pos_row;
    logic [C_ADDR_BITS-1:0] pos_addr;
    logic [11:0]            pix444;
    logic                   unused_in_bits;

    assign accept   = in_valid && in_ready;
    // A restart inside WRITE ignores freeze; only a fresh frame from IDLE honours it.
    assign start    = accept && in_sof && ((state == WRITE) || ((state == IDLE) && !freeze));
    assign do_write = start || (accept && (state == WRITE));

    // Position of the pixel being written this cycle: pixel 0 on a start, else the running counters.
    assign pos_col  = start ? '0 : col;
    assign pos_row  = start ? '0 : row;
    assign pos_addr = start ? '0 : addr;
    assign last     = (pos_col == COL_LAST) && (pos_row == ROW_LAST);

    assign pix444         = {in_data[15:12], in_data[10:7], in_data[4:1]};
    assign unused_in_bits = ^{in_data[11], in_data[6:5], in_data[0]};

`ifndef FB_WRITER_DOUBLE_BUF_EN
    assign rd_bank = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            in_ready   <= 1'b1;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            frame_cnt  <= '0;
            col        <= '0;
            row        <= '0;
            addr       <= '0;
`ifdef FB_WRITER_DOUBLE_BUF_EN
            rd_bank    <= 1'b0;
`endif
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            err_short  <= 1'b0;
            if (do_write) begin
                wr_en     <= 1'b1;
`ifdef FB_WRITER_DOUBLE_BUF_EN
                wr_addr   <= {~rd_bank, pos_addr};
`else
                wr_addr   <= pos_addr;
`endif
                wr_data   <= pix444;
                err_short <= start && (state == WRITE);
                addr      <= pos_addr + 1'b1;
                if (pos_col == COL_LAST) begin
                    col <= '0;
                    row <= pos_row + 1'b1;
                end else begin
                    col <= pos_col + 1'b1;
                    row <= pos_row;
                end
                if (last) begin
                    state      <= DONE;
                    in_ready   <= 1'b0;
                    frame_done <= 1'b1;
                    frame_cnt  <= frame_cnt + 8'd1;
`ifdef FB_WRITER_DOUBLE_BUF_EN
                    rd_bank    <= ~rd_bank;
`endif
                end else begin
                    state <= WRITE;
                end
            end else if (state == DONE) begin
                state    <= IDLE;
                in_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fb_pixel_writer.sv
// Directed bench for fb_pixel_writer: full frames, conversion, early in_sof, freeze, mid-frame reset.
// Works with or without FB_WRITER_DOUBLE_BUF_EN defined.
`timescale 1ns/1ps
module tb_fb_pixel_writer;
    localparam int C_COLS      = 80;
    localparam int C_ROWS      = 60;
    localparam int C_ADDR_BITS = 13;
    localparam int N_PIX       = C_COLS * C_ROWS;
`ifdef FB_WRITER_DOUBLE_BUF_EN
    localparam int AW = C_ADDR_BITS + 1;
`else
    localparam int AW = C_ADDR_BITS;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          freeze;
    logic          in_valid;
    logic          in_ready;
    logic          in_sof;
    logic [15:0]   in_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          rd_bank;
    logic          frame_done;
    logic          err_short;
    logic [7:0]    frame_cnt;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_cnt    = 8'd0;
    logic       m_rd_bank = 1'b0;

    always #5 clk = ~clk;

    fb_pixel_writer #(
        .C_COLS(C_COLS), .C_ROWS(C_ROWS), .C_ADDR_BITS(C_ADDR_BITS)
    ) dut (
        .clk(clk), .reset(reset), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_bank(rd_bank),
        .frame_done(frame_done), .err_short(err_short), .frame_cnt(frame_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
    endtask

    function automatic logic [11:0] to444(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

    // Expected write address: linear index, plus the write bank (complement of rd_bank) when double-buffered.
    function automatic logic [31:0] waddr(input int a);
        logic [31:0] r;
        r = 32'(a);
`ifdef FB_WRITER_DOUBLE_BUF_EN
        r[C_ADDR_BITS] = ~m_rd_bank;
`endif
        return r;
    endfunction

    task automatic stream(input int first, input int last_pix, input logic [15:0] base,
                          input logic inc, input logic sof_first, input int freeze_at);
        logic [15:0] d;
        for (int i = first; i <= last_pix; i++) begin
            d = inc ? base + 16'(i) : base;
            if (i == freeze_at) freeze = 1'b1;
            drive(1'b1, sof_first && (i == first), d);
            step();
            check("wr_en", 32'(wr_en), 1);
            check("wr_addr", 32'(wr_addr), waddr(i));
            check("wr_data", 32'(wr_data), 32'(to444(d)));
            check("err_short", 32'(err_short), 0);
            check("frame_done", 32'(frame_done), (i == N_PIX - 1) ? 1 : 0);
            check("in_ready", 32'(in_ready), (i == N_PIX - 1) ? 0 : 1);
            if (i == N_PIX - 1) begin
                m_cnt++;
`ifdef FB_WRITER_DOUBLE_BUF_EN
                m_rd_bank = ~m_rd_bank;
`endif
                check("frame_cnt_done", 32'(frame_cnt), 32'(m_cnt));
                check("rd_bank_done", 32'(rd_bank), 32'(m_rd_bank));
            end
        end
    endtask

    initial begin
        reset  = 1'b1;
        freeze = 1'b0;
        drive(1'b0, 1'b0, 16'h0000);
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_wr_en", 32'(wr_en), 0);
        check("rst_wr_addr", 32'(wr_addr), 0);
        check("rst_wr_data", 32'(wr_data), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_err_short", 32'(err_short), 0);
        check("rst_frame_cnt", 32'(frame_cnt), 0);
        check("rst_rd_bank", 32'(rd_bank), 0);
        reset = 1'b0;
        step();
        check("idle_wr_en", 32'(wr_en), 0);

        // Frame 1: all-white frame, continuous valid.
        stream(0, N_PIX - 1, 16'hFFFF, 1'b0, 1'b1, -1);
        check("white_data", 32'(wr_data), 32'h0000_0FFF);
        drive(1'b0, 1'b0, 16'h0000);
        step();
        check("post_done_ready", 32'(in_ready), 1);
        check("post_done_wr_en", 32'(wr_en), 0);
        check("post_done_fd", 32'(frame_done), 0);
        check("frame_cnt_1", 32'(frame_cnt), 1);

        // Single magenta pixel as pixel 0, then 99 more, then an early in_sof.
        drive(1'b1, 1'b1, 16'hF81F);
        step();
        check("mag_wr_en", 32'(wr_en), 1);
        check("mag_wr_addr", 32'(wr_addr), waddr(0));
        check("mag_wr_data", 32'(wr_data), 32'h0000_0F0F);
        stream(1, 99, 16'h1234, 1'b0, 1'b0, -1);
        check("p99_wr_data", 32'(wr_data), 32'h0000_014A);
        drive(1'b1, 1'b1, 16'h0F0F);
        step();
        check("restart_err_short", 32'(err_short), 1);
        check("restart_wr_en", 32'(wr_en), 1);
        check("restart_wr_addr", 32'(wr_addr), waddr(0));
        check("restart_wr_data", 32'(wr_data), 32'h0000_00E7);
        check("restart_frame_cnt", 32'(frame_cnt), 1);
        check("restart_rd_bank", 32'(rd_bank), 32'(m_rd_bank));
        check("restart_frame_done", 32'(frame_done), 0);

        // Finish the restarted frame; the err_short pulse must be a single cycle.
        stream(1, N_PIX - 1, 16'h0000, 1'b1, 1'b0, -1);
        check("frame_cnt_2", 32'(frame_cnt), 2);

        // Beat held during the DONE bubble is taken the cycle after.
        drive(1'b1, 1'b1, 16'hAAAA);
        step();
        check("held_wr_en", 32'(wr_en), 0);
        check("held_in_ready", 32'(in_ready), 1);
        step();
        check("held_accept_wr_en", 32'(wr_en), 1);
        check("held_accept_addr", 32'(wr_addr), waddr(0));
        check("held_accept_data", 32'(wr_data), 32'(to444(16'hAAAA)));

        // Freeze raised at pixel 10: frame still completes.
        stream(1, N_PIX - 1, 16'h5555, 1'b1, 1'b0, 10);
        check("frame_cnt_3", 32'(frame_cnt), 3);

        // Frozen IDLE: in_sof beats and plain beats are dropped.
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, (k % 2) == 0, 16'h1357);
            step();
            check("frozen_wr_en", 32'(wr_en), 0);
            check("frozen_err_short", 32'(err_short), 0);
        end
        check("frozen_in_ready", 32'(in_ready), 1);
        check("frozen_frame_cnt", 32'(frame_cnt), 3);

        // Unfreeze, start a frame, reset at pixel 2000.
        freeze = 1'b0;
        stream(0, 2000, 16'h2468, 1'b1, 1'b1, -1);
        #2;
        reset = 1'b1;
        drive(1'b1, 1'b0, 16'h3333);
        #1;
        m_cnt     = 8'd0;
        m_rd_bank = 1'b0;
        check("midrst_wr_en", 32'(wr_en), 0);
        check("midrst_wr_addr", 32'(wr_addr), 0);
        check("midrst_wr_data", 32'(wr_data), 0);
        check("midrst_frame_cnt", 32'(frame_cnt), 0);
        check("midrst_rd_bank", 32'(rd_bank), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        step();
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check("after_rst_no_write", 32'(wr_en), 0);
        end
        drive(1'b1, 1'b1, 16'h07E0);
        step();
        check("after_rst_sof_wr_en", 32'(wr_en), 1);
        check("after_rst_sof_addr", 32'(wr_addr), waddr(0));
        check("after_rst_sof_data", 32'(wr_data), 32'h0000_00F0);
        drive(1'b0, 1'b0, 16'h0000);
        step();
        check("final_wr_en", 32'(wr_en), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
